// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, special register IDs and the
// default datapath width.
package y86_pkg;

  localparam int unsigned N_DEFAULT = 64;
  localparam int unsigned NUM_REGS  = 15;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } reg_ids_t;

endpackage

// File: rtl/decode_regfile_regfile.sv
// 15-entry register file: two read ports plus a debug port, two write ports
// where the M port overrides the E port on a shared destination.
module regfile
  import y86_pkg::*;
#(
  parameter int unsigned n = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we_i,
  input  logic [3:0]   dst_e_i,
  input  logic [n-1:0] val_e_i,
  input  logic [3:0]   dst_m_i,
  input  logic [n-1:0] val_m_i,
  input  logic [3:0]   rd_a_i,
  input  logic [3:0]   rd_b_i,
  input  logic [3:0]   rd_dbg_i,
  output logic [n-1:0] rd_a_o,
  output logic [n-1:0] rd_b_o,
  output logic [n-1:0] rd_dbg_o
);

  logic [NUM_REGS-1:0][n-1:0] regs_q, regs_d;

  // M is applied after E so popq %rsp lands valM in rsp.
  always_comb begin
    regs_d = regs_q;
    if (we_i) begin
      if (dst_e_i != RNONE) regs_d[dst_e_i] = val_e_i;
      if (dst_m_i != RNONE) regs_d[dst_m_i] = val_m_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  // ID 0xF has no storage; it reads as zero.
  always_comb begin
    rd_a_o   = (rd_a_i   == RNONE) ? '0 : regs_q[rd_a_i];
    rd_b_o   = (rd_b_i   == RNONE) ? '0 : regs_q[rd_b_i];
    rd_dbg_o = (rd_dbg_i == RNONE) ? '0 : regs_q[rd_dbg_i];
  end

endmodule

// File: rtl/decode_regfile.sv
// Y86-64 decode/write-back: derives src/dst register IDs from fetch fields and
// wraps the register file that reads operands and commits valE/valM.
module decode_regfile
  import y86_pkg::*;
#(
  parameter int unsigned n = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   icode,
  input  logic [3:0]   rA,
  input  logic [3:0]   rB,
  input  logic         cnd,
  input  logic [n-1:0] valE,
  input  logic [n-1:0] valM,
  input  logic         wb_en,
  input  logic [3:0]   dbg_sel,
  output logic [n-1:0] valA,
  output logic [n-1:0] valB,
  output logic [3:0]   srcA,
  output logic [3:0]   srcB,
  output logic [3:0]   dstE,
  output logic [3:0]   dstM,
  output logic [n-1:0] dbg_val
);

  reg_ids_t ids;

  always_comb begin
    ids = '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
    case (icode)
      IRRMOVQ: begin
        ids.src_a = rA;
        ids.dst_e = cnd ? rB : RNONE;
      end
      IIRMOVQ: ids.dst_e = rB;
      IRMMOVQ: begin
        ids.src_a = rA;
        ids.src_b = rB;
      end
      IMRMOVQ: begin
        ids.src_b = rB;
        ids.dst_m = rA;
      end
      IOPQ: begin
        ids.src_a = rA;
        ids.src_b = rB;
        ids.dst_e = rB;
      end
      ICALL: begin
        ids.src_b = RRSP;
        ids.dst_e = RRSP;
      end
      IRET: begin
        ids.src_a = RRSP;
        ids.src_b = RRSP;
        ids.dst_e = RRSP;
      end
      IPUSHQ: begin
        ids.src_a = rA;
        ids.src_b = RRSP;
        ids.dst_e = RRSP;
      end
      IPOPQ: begin
        ids.src_a = RRSP;
        ids.src_b = RRSP;
        ids.dst_e = RRSP;
        ids.dst_m = rA;
      end
      default: ;
    endcase
  end

  assign srcA = ids.src_a;
  assign srcB = ids.src_b;
  assign dstE = ids.dst_e;
  assign dstM = ids.dst_m;

  regfile #(.n(n)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (wb_en),
    .dst_e_i  (ids.dst_e),
    .val_e_i  (valE),
    .dst_m_i  (ids.dst_m),
    .val_m_i  (valM),
    .rd_a_i   (ids.src_a),
    .rd_b_i   (ids.src_b),
    .rd_dbg_i (dbg_sel),
    .rd_a_o   (valA),
    .rd_b_o   (valB),
    .rd_dbg_o (dbg_val)
  );

endmodule
